// File: rtl/wb_arbiter.sv
// Write-back arbiter: owns the register-file write port, merging ALU results with
// FIFO-buffered, extended load returns, and emits a registered commit stream.
module wb_arbiter #(
    parameter  int unsigned FIFO_DEPTH = 2,
    parameter  int unsigned MAX_WAIT   = 4,
    localparam int unsigned REG_W      = 64,
    localparam int unsigned ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [ADDR_W-1:0] alu_waddr_i,
    input  logic [REG_W-1:0]  alu_wdata_i,
    input  logic [REG_W-1:0]  alu_pc_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [ADDR_W-1:0] lsu_waddr_i,
    input  logic [REG_W-1:0]  lsu_rdata_i,
    input  logic [1:0]        lsu_size_i,
    input  logic              lsu_signed_i,
    input  logic [REG_W-1:0]  lsu_pc_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [REG_W-1:0]  wdata_o,
    output logic              commit_valid_o,
    output logic [REG_W-1:0]  commit_pc_o,
    output logic [63:0]       commit_cnt_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AGE_W = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [REG_W-1:0]  data;
        logic [REG_W-1:0]  pc;
    } wb_entry_t;

    wb_entry_t         fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [AGE_W-1:0]  age_q, age_d;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [REG_W-1:0]  wdata_q, wdata_d;
    logic              cv_q, cv_d;
    logic [REG_W-1:0]  pc_q, pc_d;
    logic [63:0]       cnt_q, cnt_d;

    logic              force_load;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              take_alu;
    logic [REG_W-1:0]  ext_data;
    wb_entry_t         push_entry;
    wb_entry_t         sel_entry;

    // Ready signals depend only on registered state.
    assign fifo_empty  = (count_q == '0);
    assign force_load  = (age_q >= AGE_W'(MAX_WAIT));
    assign alu_ready_o = ~force_load;
    assign lsu_ready_o = (count_q < CNT_W'(FIFO_DEPTH));

    assign push     = lsu_valid_i & lsu_ready_o;
    assign pop      = ~fifo_empty & (force_load | ~alu_valid_i);
    assign take_alu = alu_valid_i & alu_ready_o;

    // Load data is extended once, at push time.
    always_comb begin
        ext_data = lsu_rdata_i;
        case (lsu_size_i)
            2'b00:   ext_data = {{(REG_W-8){lsu_signed_i & lsu_rdata_i[7]}}, lsu_rdata_i[7:0]};
            2'b01:   ext_data = {{(REG_W-16){lsu_signed_i & lsu_rdata_i[15]}}, lsu_rdata_i[15:0]};
            2'b10:   ext_data = {{(REG_W-32){lsu_signed_i & lsu_rdata_i[31]}}, lsu_rdata_i[31:0]};
            default: ext_data = lsu_rdata_i;
        endcase
    end

    assign push_entry = '{waddr: lsu_waddr_i, data: ext_data, pc: lsu_pc_i};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        age_d     = age_q;
        we_d      = 1'b0;
        cv_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        sel_entry = fifo_q[rd_ptr_q];

        if (take_alu) begin
            sel_entry = '{waddr: alu_waddr_i, data: alu_wdata_i, pc: alu_pc_i};
        end

        if (push) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        if (push && !pop) begin
            count_d = CNT_W'(count_q + 1'b1);
        end else if (!push && pop) begin
            count_d = CNT_W'(count_q - 1'b1);
        end

        // Age of the head entry; saturates so it can never wrap back below MAX_WAIT.
        if (pop || fifo_empty) begin
            age_d = '0;
        end else if (age_q != '1) begin
            age_d = AGE_W'(age_q + 1'b1);
        end

        if (pop || take_alu) begin
            we_d    = |sel_entry.waddr;
            cv_d    = 1'b1;
            waddr_d = sel_entry.waddr;
            wdata_d = sel_entry.data;
            pc_d    = sel_entry.pc;
            cnt_d   = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            cv_q     <= 1'b0;
            pc_q     <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            age_q    <= age_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            cv_q     <= cv_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    assign we_o           = we_q;
    assign waddr_o        = waddr_q;
    assign wdata_o        = wdata_q;
    assign commit_valid_o = cv_q;
    assign commit_pc_o    = pc_q;
    assign commit_cnt_o   = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the write-back selection rules.
module tb_wb_arbiter;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned MAX_WAIT   = 4;

    logic        clk;
    logic        rst;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_waddr_i;
    logic [63:0] alu_wdata_i;
    logic [63:0] alu_pc_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_waddr_i;
    logic [63:0] lsu_rdata_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_signed_i;
    logic [63:0] lsu_pc_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [63:0] wdata_o;
    logic        commit_valid_o;
    logic [63:0] commit_pc_o;
    logic [63:0] commit_cnt_o;

    wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_waddr_i(alu_waddr_i),
        .alu_wdata_i(alu_wdata_i), .alu_pc_i(alu_pc_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_waddr_i(lsu_waddr_i),
        .lsu_rdata_i(lsu_rdata_i), .lsu_size_i(lsu_size_i), .lsu_signed_i(lsu_signed_i),
        .lsu_pc_i(lsu_pc_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o), .commit_cnt_o(commit_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  waddr;
        logic [63:0] data;
        logic [63:0] pc;
    } ent_t;

    int          n_tests;
    int          n_fail;
    ent_t        ld_q[$];
    int          age_m;
    bit          alu_acc;
    logic        exp_we;
    logic        exp_cv;
    logic [4:0]  exp_waddr;
    logic [63:0] exp_wdata;
    logic [63:0] exp_pc;
    logic [63:0] exp_cnt;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Extension by mask arithmetic on the loaded width.
    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] sz,
                                           input logic sg);
        int unsigned bits;
        logic [63:0] mask;
        bits = 32'd8 << sz;
        if (bits == 64) return raw;
        mask = (64'd1 << bits) - 64'd1;
        if (sg && raw[bits-1]) return raw | ~mask;
        return raw & mask;
    endfunction

    task automatic model_reset();
        ld_q.delete();
        age_m     = 0;
        alu_acc   = 1'b1;
        exp_we    = 1'b0;
        exp_cv    = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        exp_pc    = '0;
        exp_cnt   = '0;
    endtask

    task automatic do_reset();
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_we",        64'(we_o), 64'd0);
        check_eq("rst_cv",        64'(commit_valid_o), 64'd0);
        check_eq("rst_waddr",     64'(waddr_o), 64'd0);
        check_eq("rst_wdata",     wdata_o, 64'd0);
        check_eq("rst_pc",        commit_pc_o, 64'd0);
        check_eq("rst_cnt",       commit_cnt_o, 64'd0);
        check_eq("rst_alu_ready", 64'(alu_ready_o), 64'd1);
        check_eq("rst_lsu_ready", 64'(lsu_ready_o), 64'd1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive, check readies, advance the model, check the output stage.
    task automatic step(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                        input logic [63:0] ap, input logic lv, input logic [4:0] la,
                        input logic [63:0] lr, input logic [1:0] ls, input logic lsg,
                        input logic [63:0] lp);
        ent_t h;
        bit   force_ld, lrdy, was_empty, do_pop, do_alu;
        @(negedge clk);
        alu_valid_i = av;  alu_waddr_i = aa; alu_wdata_i = ad; alu_pc_i = ap;
        lsu_valid_i = lv;  lsu_waddr_i = la; lsu_rdata_i = lr; lsu_size_i = ls;
        lsu_signed_i = lsg; lsu_pc_i = lp;
        #1;
        force_ld  = (age_m >= int'(MAX_WAIT));
        lrdy      = (ld_q.size() < int'(FIFO_DEPTH));
        check_eq("alu_ready", 64'(alu_ready_o), 64'(!force_ld));
        check_eq("lsu_ready", 64'(lsu_ready_o), 64'(lrdy));
        was_empty = (ld_q.size() == 0);
        do_pop    = !was_empty && (force_ld || !av);
        do_alu    = av && !force_ld;
        alu_acc   = do_alu;
        exp_we    = 1'b0;
        exp_cv    = 1'b0;
        if (do_pop) begin
            h = ld_q.pop_front();
            exp_waddr = h.waddr; exp_wdata = h.data; exp_pc = h.pc;
        end else if (do_alu) begin
            exp_waddr = aa; exp_wdata = ad; exp_pc = ap;
        end
        if (do_pop || do_alu) begin
            exp_cv  = 1'b1;
            exp_we  = (exp_waddr != 5'd0);
            exp_cnt = exp_cnt + 64'd1;
        end
        if (do_pop || was_empty) age_m = 0;
        else if (age_m < 7) age_m++;
        if (lv && lrdy) ld_q.push_back('{waddr: la, data: extend(lr, ls, lsg), pc: lp});
        @(posedge clk);
        #1;
        check_eq("we",     64'(we_o), 64'(exp_we));
        check_eq("cv",     64'(commit_valid_o), 64'(exp_cv));
        check_eq("waddr",  64'(waddr_o), 64'(exp_waddr));
        check_eq("wdata",  wdata_o, exp_wdata);
        check_eq("pc",     commit_pc_o, exp_pc);
        check_eq("cnt",    commit_cnt_o, exp_cnt);
    endtask

    task automatic idle_step();
        step(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 64'd0);
    endtask

    task automatic load_step(input logic [4:0] la, input logic [63:0] lr, input logic [1:0] ls,
                             input logic lsg, input logic [63:0] lp);
        step(1'b0, 5'd0, 64'd0, 64'd0, 1'b1, la, lr, ls, lsg, lp);
    endtask

    logic        ra_v;
    logic [4:0]  ra_a;
    logic [63:0] ra_d;
    logic [63:0] ra_p;
    int          a_n;

    initial begin
        n_tests = 0; n_fail = 0;
        clk = 1'b0; rst = 1'b0;
        alu_valid_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0; alu_pc_i = '0;
        lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_rdata_i = '0; lsu_size_i = '0;
        lsu_signed_i = 1'b0; lsu_pc_i = '0;
        model_reset();
        do_reset();

        // ALU stream with an x0 destination in the middle of retirement.
        step(1'b1, 5'd1, 64'h11, 64'h1000, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 64'd0);
        check_eq("alu0_we", 64'(we_o), 64'd1);
        check_eq("alu0_cnt", commit_cnt_o, 64'd1);
        step(1'b1, 5'd2, 64'h22, 64'h1004, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 64'd0);
        check_eq("alu1_we", 64'(we_o), 64'd1);
        check_eq("alu1_cnt", commit_cnt_o, 64'd2);
        step(1'b1, 5'd0, 64'h33, 64'h1008, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 64'd0);
        check_eq("alu2_we", 64'(we_o), 64'd0);
        check_eq("alu2_cv", 64'(commit_valid_o), 64'd1);
        check_eq("alu2_cnt", commit_cnt_o, 64'd3);

        // Back-to-back loads with ALU idle: each push overlaps the previous pop.
        load_step(5'd3, 64'h80, 2'b00, 1'b1, 64'h2000);
        load_step(5'd4, 64'h80, 2'b00, 1'b0, 64'h2004);
        check_eq("ext_sb", wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
        check_eq("pp_waddr0", 64'(waddr_o), 64'd3);
        check_eq("pp_ready", 64'(lsu_ready_o), 64'd1);
        load_step(5'd5, 64'h8000_0000, 2'b10, 1'b1, 64'h2008);
        check_eq("ext_ub", wdata_o, 64'h80);
        check_eq("pp_waddr1", 64'(waddr_o), 64'd4);
        idle_step();
        check_eq("ext_sw", wdata_o, 64'hFFFF_FFFF_8000_0000);
        check_eq("pp_waddr2", 64'(waddr_o), 64'd5);
        idle_step();

        // Backpressure and starvation guard under a continuous ALU stream.
        do_reset();
        a_n = 0;
        for (int c = 0; c < 7; c++) begin
            step(1'b1, 5'(10 + a_n), 64'(100 + a_n), 64'(a_n), 1'b1,
                 (c < 2) ? 5'(20 + c) : 5'd22, 64'(c), 2'b11, 1'b0, 64'(c + 64));
            if (alu_acc) a_n++;
            if (c == 1) check_eq("bp_lsu_full", 64'(lsu_ready_o), 64'd0);
            if (c == 4) check_eq("bp_alu_stall", 64'(alu_ready_o), 64'd0);
            if (c == 5) begin
                check_eq("bp_force_we", 64'(we_o), 64'd1);
                check_eq("bp_force_waddr", 64'(waddr_o), 64'd20);
                check_eq("bp_alu_resume", 64'(alu_ready_o), 64'd1);
            end
        end

        // Reset while two loads are buffered: they must never write.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle_step();
            check_eq("post_rst_we", 64'(we_o), 64'd0);
        end
        step(1'b1, 5'd7, 64'h77, 64'h3000, 1'b0, 5'd0, 64'd0, 2'b00, 1'b0, 64'd0);
        check_eq("post_rst_cnt", commit_cnt_o, 64'd1);

        // Randomized traffic; an offered ALU result is held until accepted.
        ra_v = 1'b0; ra_a = '0; ra_d = '0; ra_p = '0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if (alu_acc || !ra_v) begin
                ra_v = ($urandom_range(0, 9) < ((i < 200) ? 9 : 5));
                ra_a = 5'($urandom_range(0, 31));
                ra_d = {$urandom, $urandom};
                ra_p = {$urandom, $urandom};
            end
            step(ra_v, ra_a, ra_d, ra_p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that owns the single register-file write port (`we_i`/`waddr_i`/`wdata_i` of REGFILE). It merges results from the ALU pipeline and the load/store unit, buffers load returns in a small FIFO, and sign- or zero-extends load data. It also emits a registered commit stream (pc plus retired-instruction count) for the difftest harness.

## Interface
Parameters:
- FIFO_DEPTH, 2, load-return buffer entries; power of two, ≥2
- MAX_WAIT, 4, cycles a load may wait at the FIFO head before the ALU is stalled; range 1..7

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid_i  in  1  ALU result present
- alu_ready_o  out  1  ALU result accepted this cycle when high with alu_valid_i
- alu_waddr_i  in  `RegAddrBus  destination register
- alu_wdata_i  in  `RegBus  result
- alu_pc_i  in  `RegBus  pc of the instruction
- lsu_valid_i  in  1  load result present
- lsu_ready_o  out  1  FIFO can accept
- lsu_waddr_i  in  `RegAddrBus  destination register
- lsu_rdata_i  in  `RegBus  raw load data, right-aligned
- lsu_size_i  in  2  00 byte, 01 half, 10 word, 11 dword
- lsu_signed_i  in  1  1 = sign-extend, 0 = zero-extend
- lsu_pc_i  in  `RegBus  pc of the load
- we_o  out  1  register-file write enable
- waddr_o  out  `RegAddrBus  register-file write address
- wdata_o  out  `RegBus  register-file write data
- commit_valid_o  out  1  one instruction retired
- commit_pc_o  out  `RegBus  pc of the retired instruction
- commit_cnt_o  out  64  running retired-instruction count

## Operation
- Load push: occurs when lsu_valid_i && lsu_ready_o. Data is extended per lsu_size_i/lsu_signed_i at push time and stored with waddr and pc.
- lsu_ready_o = (count < FIFO_DEPTH), taken from registered count only.
- Starvation guard: 3-bit age counter.
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on every pop or when the FIFO is empty.
  - force_load = (age ≥ MAX_WAIT).
- alu_ready_o = !force_load (registered state only, so no combinational path from valid inputs).
- Selection each cycle:
  - If force_load, pop the FIFO head.
  - Else if alu_valid_i, take the ALU result.
  - Else if the FIFO is non-empty, pop the head.
  - Else idle.
- Selected result is registered into the output stage:
  - commit_valid_o = 1, commit_pc_o = pc.
  - we_o = (waddr ≠ 0); x0 writes retire but never write.
  - waddr_o/wdata_o loaded with the selected result.
- Idle cycle: we_o = 0, commit_valid_o = 0; waddr_o, wdata_o and commit_pc_o hold their last value.
- commit_cnt_o increments by 1 in the same cycle commit_valid_o is asserted; it reflects the count including that instruction and wraps modulo 2^64.
- Push and pop in the same cycle: legal whenever lsu_ready_o is high; count is unchanged.
- When full, lsu_ready_o = 0 for the whole cycle even if a pop happens that cycle.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: we_o, commit_valid_o, waddr_o, wdata_o and commit_pc_o = 0; commit_cnt_o = 0.
  - Internal state: FIFO emptied, age cleared.
  - Ready signals: alu_ready_o = 1 and lsu_ready_o = 1 while rst is held.
- Reset mid-operation discards buffered loads and the in-flight output-stage write.
- ALU latency: accepted in cycle N → we_o/commit_valid_o in cycle N+1.
- Load latency: pushed in cycle N → earliest pop in N+1 → we_o in N+2. There is no bypass.
- At most one write and one commit per cycle.
- Load results leave in FIFO order. ALU and load results interleave only as dictated by the selection rules above.
- An ALU result must be held by its source while alu_ready_o = 0.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs 0, commit_cnt_o = 0, lsu_ready_o = 1, with no clock edge required.
- ALU stream: alu_valid_i for 3 cycles, waddr 1,2,0 → we_o = 1,1,0 in cycles N+1..N+3; commit_valid_o high all 3; commit_cnt_o = 1,2,3.
- Load extension:
  - rdata 0x80, size 00, signed → wdata_o 0xFFFF_FFFF_FFFF_FF80.
  - rdata 0x80, size 00, unsigned → wdata_o 0x80.
  - rdata 0x8000_0000, size 10, signed → wdata_o 0xFFFF_FFFF_8000_0000.
- Full/backpressure: ALU continuously valid, 3 loads offered back-to-back → lsu_ready_o drops after 2 pushes. After MAX_WAIT = 4 waiting cycles, alu_ready_o = 0 for one cycle and the first load writes.
- Simultaneous push/pop: FIFO count 1, ALU idle, new load pushed → head pops the same cycle, count stays 1, loads retire in order on consecutive cycles.
- Reset with 2 buffered loads → no further writes after reset release, and commit_cnt_o restarts from 1 on the next commit.
